vanilla_issue_queue: RTL

//  Registered instruction queue with dual-issue selection between fetch and execute in the vanilla core.

---
 rtl/vanilla_issue_queue.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/vanilla_issue_queue.sv
// vanilla_issue_queue
// Circular instruction queue sitting between fetch and execute. Fetch writes
// up to FETCH_W pre-decoded instructions per beat; each cycle the oldest entry
// is offered for issue, together with the next-oldest when the two form an
// independent INT/FP pair.
//
// Ports
//   clk_i, reset_n_i          clock, asynchronous active-low reset
//   flush_i                   drop queued and same-cycle incoming entries
//   fetch_v_i / fetch_cnt_i   beat valid and number of valid slots (slot 0 oldest)
//   fetch_instr_i             raw instruction payloads, FETCH_W slots
//   fetch_rd/rs1/rs2_i        register tags {is_fp_file, index}
//   fetch_wr_rd/rd_rs1/rd_rs2_i   operand-use flags per slot
//   fetch_is_fp/is_fp_load/special_i  class flags per slot
//   fetch_ready_o             a full beat fits (from registered occupancy)
//   issue_v_o                 bit0 oldest valid, bit1 second issued alongside
//   issue_instr_o             {second, oldest} payloads
//   issue_int_slot_o          issue slot holding the INT-class op
//   issue_ready_i             execute accepts the bundle
//   dual_cnt_o, single_cnt_o  handshake statistics (wrapping)
module vanilla_issue_queue #(
    parameter int FETCH_W = 2,
    parameter int DEPTH   = 8,
    parameter int INSTR_W = 32,
    parameter int REG_W   = 6,
    parameter int CNT_W   = 32
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic                           flush_i,
    input  logic                           fetch_v_i,
    input  logic [$clog2(FETCH_W+1)-1:0]   fetch_cnt_i,
    input  logic [FETCH_W*INSTR_W-1:0]     fetch_instr_i,
    input  logic [FETCH_W*REG_W-1:0]       fetch_rd_i,
    input  logic [FETCH_W*REG_W-1:0]       fetch_rs1_i,
    input  logic [FETCH_W*REG_W-1:0]       fetch_rs2_i,
    input  logic [FETCH_W-1:0]             fetch_wr_rd_i,
    input  logic [FETCH_W-1:0]             fetch_rd_rs1_i,
    input  logic [FETCH_W-1:0]             fetch_rd_rs2_i,
    input  logic [FETCH_W-1:0]             fetch_is_fp_i,
    input  logic [FETCH_W-1:0]             fetch_is_fp_load_i,
    input  logic [FETCH_W-1:0]             fetch_special_i,
    output logic                           fetch_ready_o,
    output logic [1:0]                     issue_v_o,
    output logic [2*INSTR_W-1:0]           issue_instr_o,
    output logic                           issue_int_slot_o,
    input  logic                           issue_ready_i,
    output logic [CNT_W-1:0]               dual_cnt_o,
    output logic [CNT_W-1:0]               single_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int FC_W  = $clog2(FETCH_W + 1);

    // Flag bit positions inside a stored entry
    localparam int F_WR  = 0;
    localparam int F_RS1 = 1;
    localparam int F_RS2 = 2;
    localparam int F_FP  = 3;
    localparam int F_FPL = 4;
    localparam int F_SP  = 5;

    // Entry storage (payload only, no reset needed)
    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [REG_W-1:0]   rd_mem    [DEPTH];
    logic [REG_W-1:0]   rs1_mem   [DEPTH];
    logic [REG_W-1:0]   rs2_mem   [DEPTH];
    logic [5:0]         flag_mem  [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [CNT_W-1:0] dual_cnt_q, dual_cnt_d;
    logic [CNT_W-1:0] single_cnt_q, single_cnt_d;

    logic [PTR_W-1:0] next_ptr;
    logic [5:0]       head_flags, next_flags;
    logic [REG_W-1:0] head_rd;
    logic             head_int, next_int;
    logic             head_writes, raw_hazard, waw_hazard, fp_load_pair, pair_ok;
    logic             push_fire, pop_fire;
    logic [OCC_W-1:0] push_num, pop_num;

    logic [PTR_W-1:0] slot_idx [FETCH_W];
    logic [FETCH_W-1:0] slot_we;

    // ------------------------------------------------------------------
    // Pair selection between head and next-oldest entry
    // ------------------------------------------------------------------
    assign next_ptr   = rd_ptr_q + PTR_W'(1);
    assign head_flags = flag_mem[rd_ptr_q];
    assign next_flags = flag_mem[next_ptr];
    assign head_rd    = rd_mem[rd_ptr_q];

    // FP loads execute in the INT pipe, so they count as INT class
    assign head_int = !head_flags[F_FP] || head_flags[F_FPL];
    assign next_int = !next_flags[F_FP] || next_flags[F_FPL];

    // Tag 0 is integer x0 and never carries a dependency; FP tag {1,0} does
    assign head_writes  = head_flags[F_WR] && (head_rd != '0);
    assign raw_hazard   = head_writes &&
                          ((next_flags[F_RS1] && (rs1_mem[next_ptr] == head_rd)) ||
                           (next_flags[F_RS2] && (rs2_mem[next_ptr] == head_rd)));
    assign waw_hazard   = head_writes && next_flags[F_WR] && (rd_mem[next_ptr] == head_rd);
    assign fp_load_pair = head_flags[F_FPL] && next_flags[F_FPL];

    assign pair_ok = !head_flags[F_SP] && (head_int != next_int) &&
                     !fp_load_pair && !raw_hazard && !waw_hazard;

    assign issue_v_o[0]     = (occ_q != '0);
    assign issue_v_o[1]     = (occ_q >= OCC_W'(2)) && pair_ok;
    assign issue_instr_o    = {instr_mem[next_ptr], instr_mem[rd_ptr_q]};
    assign issue_int_slot_o = !head_int;

    assign fetch_ready_o = (OCC_W'(DEPTH) - occ_q) >= OCC_W'(FETCH_W);
    assign dual_cnt_o    = dual_cnt_q;
    assign single_cnt_o  = single_cnt_q;

    // ------------------------------------------------------------------
    // Handshakes; flush suppresses both push and the counted pop
    // ------------------------------------------------------------------
    assign push_fire = fetch_v_i && fetch_ready_o && !flush_i;
    assign pop_fire  = issue_v_o[0] && issue_ready_i && !flush_i;
    assign push_num  = OCC_W'(fetch_cnt_i);
    assign pop_num   = issue_v_o[1] ? OCC_W'(2) : OCC_W'(1);

    generate
        for (genvar gi = 0; gi < FETCH_W; gi++) begin : g_slot
            assign slot_idx[gi] = wr_ptr_q + PTR_W'(gi);
            assign slot_we[gi]  = push_fire && (FC_W'(gi) < fetch_cnt_i);
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        for (int s = 0; s < FETCH_W; s++) begin
            if (slot_we[s]) begin
                instr_mem[slot_idx[s]] <= fetch_instr_i[s*INSTR_W +: INSTR_W];
                rd_mem[slot_idx[s]]    <= fetch_rd_i[s*REG_W +: REG_W];
                rs1_mem[slot_idx[s]]   <= fetch_rs1_i[s*REG_W +: REG_W];
                rs2_mem[slot_idx[s]]   <= fetch_rs2_i[s*REG_W +: REG_W];
                flag_mem[slot_idx[s]]  <= {fetch_special_i[s], fetch_is_fp_load_i[s],
                                           fetch_is_fp_i[s], fetch_rd_rs2_i[s],
                                           fetch_rd_rs1_i[s], fetch_wr_rd_i[s]};
            end
        end
    end

    always_comb begin
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        occ_d        = occ_q;
        dual_cnt_d   = dual_cnt_q;
        single_cnt_d = single_cnt_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (pop_fire) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(pop_num);
                if (issue_v_o[1]) dual_cnt_d   = dual_cnt_q + CNT_W'(1);
                else              single_cnt_d = single_cnt_q + CNT_W'(1);
            end
            if (push_fire) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(fetch_cnt_i);
            end
            occ_d = occ_q + (push_fire ? push_num : '0) - (pop_fire ? pop_num : '0);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            occ_q        <= '0;
            dual_cnt_q   <= '0;
            single_cnt_q <= '0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            occ_q        <= occ_d;
            dual_cnt_q   <= dual_cnt_d;
            single_cnt_q <= single_cnt_d;
        end
    end

endmodule
